pixel_req_arbiter: RTL and testbench

- Shares one pixel-fetch port (frame/pixel memory) between NUM_REQ requesters, each a control-style unit with an addr_pixel/request_pixel/pixel/pixel_avail interface.
- Captures single-cycle request pulses and grants them round-robin, one outstanding memory access at a time.
- Routes the returned pixel to the owning requester. A watchdog stops a missing memory response from deadlocking the system.

---
 rtl/pixel_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/pixel_req_arbiter.sv | 129 ++++++++++++
 tb/tb_pixel_req_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_arb_pkg.sv
// Shared types and helpers for the pixel-request arbiter: FSM states,
// default timeout payload and the round-robin winner search.
package pixel_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;
  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  // First set bit of pending searching ptr, ptr+1, ... modulo n; returns ptr when none set.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   pending,
                                                   input logic [MAX_IDX_W-1:0] ptr,
                                                   input int unsigned          n);
    logic [MAX_IDX_W-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = MAX_IDX_W'(({28'd0, ptr} + k) % n);
      if (!found && (k < n) && pending[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational winner over a request vector plus a
// registered pointer that moves past the winner whenever a grant is taken.
module rr_arbiter
  import pixel_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic               advance_i,
  output logic [IDX_W-1:0]   winner_c_o
);

  logic [IDX_W-1:0] ptr_q;

  assign winner_c_o = IDX_W'(rr_pick(MAX_REQ'(pending_i), MAX_IDX_W'(ptr_q), NUM_REQ));

  always_ff @(posedge clk) begin
    if (res) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (winner_c_o == IDX_W'(NUM_REQ - 1)) ? '0 : winner_c_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pixel_req_arbiter.sv
// Shares one pixel-fetch port between NUM_REQ requesters: captures request
// pulses, grants round-robin with one access in flight, routes the reply back.
module pixel_req_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int unsigned           NUM_REQ      = 4,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           TIMEOUT      = 1023,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_DATA_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic [NUM_REQ-1:0]            req_pixel,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0]         rsp_pixel,
  output logic [NUM_REQ-1:0]            rsp_avail,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_req,
  input  logic [DATA_WIDTH-1:0]         mem_pixel,
  input  logic                          mem_avail,
  input  logic                          clear_err,
  output logic                          busy,
  output logic                          err_timeout,
  output logic                          err_overflow
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_e                  state_q;
  logic [NUM_REQ-1:0]      pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]   addr_q [NUM_REQ];
  logic [IDX_W-1:0]        grant_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    mem_req_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   rsp_pixel_q;
  logic [NUM_REQ-1:0]      rsp_avail_q;
  logic                    err_timeout_q, err_overflow_q;

  logic [IDX_W-1:0]        winner_c;
  logic                    grant_c, rsp_fire_c, expire_c, overflow_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .res        (res),
    .pending_i  (pending_q),
    .advance_i  (grant_c),
    .winner_c_o (winner_c)
  );

  assign grant_c    = (state_q == IDLE) && (|pending_q);
  // The first WAIT cycle is the mem_req cycle; the source may not answer in it.
  assign rsp_fire_c = (state_q == WAIT) && !mem_req_q && mem_avail;
  assign expire_c   = (state_q == WAIT) && !rsp_fire_c && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign overflow_c = |(req_pixel & pending_q);

  // A granted requester's pending bit was set, so its same-cycle pulse is already an overflow.
  always_comb begin
    pending_d = pending_q | req_pixel;
    if (grant_c) begin
      pending_d[winner_c] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      grant_q        <= '0;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      rsp_pixel_q    <= '0;
      rsp_avail_q    <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      pending_q      <= pending_d;
      mem_req_q      <= 1'b0;
      rsp_avail_q    <= '0;
      err_overflow_q <= overflow_c | (err_overflow_q & ~clear_err);
      err_timeout_q  <= expire_c   | (err_timeout_q  & ~clear_err);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pixel[i] && !pending_q[i]) begin
          addr_q[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            grant_q    <= winner_c;
            mem_addr_q <= addr_q[winner_c];
            mem_req_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rsp_fire_c) begin
            rsp_pixel_q <= mem_pixel;
            rsp_avail_q <= ONE_HOT0 << grant_q;
            state_q     <= IDLE;
          end else if (expire_c) begin
            rsp_pixel_q <= TIMEOUT_DATA;
            rsp_avail_q <= ONE_HOT0 << grant_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_pixel    = rsp_pixel_q;
  assign rsp_avail    = rsp_avail_q;
  assign mem_addr     = mem_addr_q;
  assign mem_req      = mem_req_q;
  assign busy         = (state_q == WAIT);
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_pixel_req_arbiter.sv
// Directed bench for pixel_req_arbiter: expected grants are queued when
// requests are driven and popped when the memory port / response strobes fire.
module tb_pixel_req_arbiter;

  logic         clk = 1'b0;
  logic         res;
  logic [3:0]   req_pixel;
  logic [127:0] req_addr;
  logic [31:0]  rsp_pixel;
  logic [3:0]   rsp_avail;
  logic [31:0]  mem_addr;
  logic         mem_req;
  logic [31:0]  mem_pixel;
  logic         mem_avail;
  logic         clear_err;
  logic         busy;
  logic         err_timeout;
  logic         err_overflow;

  typedef struct {
    int unsigned idx;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pixel_req_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .res(res), .req_pixel(req_pixel), .req_addr(req_addr),
    .rsp_pixel(rsp_pixel), .rsp_avail(rsp_avail), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_pixel(mem_pixel), .mem_avail(mem_avail), .clear_err(clear_err), .busy(busy),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int unsigned i, input logic [31:0] a, input bit push);
    exp_t e;
    req_pixel[i]         = 1'b1;
    req_addr[i*32 +: 32] = a;
    if (push) begin
      e.idx  = i;
      e.addr = a;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for mem_req, check it against the scoreboard, answer after delay cycles.
  task automatic serve(input int delay, input logic [31:0] data);
    exp_t e;
    int   n;
    logic seen;
    n    = 0;
    seen = mem_req;
    while (seen !== 1'b1 && n < 20) begin
      step();
      n++;
      seen = mem_req;
    end
    check("serve_mem_req", 64'(seen), 64'h1);
    check("serve_sb_avail", 64'(sb.size() != 0), 64'h1);
    if (seen === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      check("serve_mem_addr", 64'(mem_addr), 64'(e.addr));
      step();
      check("serve_req_pulse", 64'(mem_req), 64'h0);
      repeat (delay - 1) step();
      mem_avail = 1'b1;
      mem_pixel = data;
      step();
      mem_avail = 1'b0;
      check("serve_rsp_avail", 64'(rsp_avail), 64'(4'b0001 << e.idx));
      check("serve_rsp_pixel", 64'(rsp_pixel), 64'(data));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    res       = 1'b1;
    req_pixel = '0;
    req_addr  = '0;
    mem_pixel = '0;
    mem_avail = 1'b0;
    clear_err = 1'b0;
    repeat (2) step();
    check("rst_busy",      64'(busy),         64'h0);
    check("rst_mem_req",   64'(mem_req),      64'h0);
    check("rst_mem_addr",  64'(mem_addr),     64'h0);
    check("rst_rsp_avail", 64'(rsp_avail),    64'h0);
    check("rst_rsp_pixel", 64'(rsp_pixel),    64'h0);
    check("rst_err_to",    64'(err_timeout),  64'h0);
    check("rst_err_ov",    64'(err_overflow), 64'h0);
    res = 1'b0;

    // single request, exact latencies
    drive_req(0, 32'h0000_0100, 1'b1);
    step();
    req_pixel = '0;
    check("t1_no_early_req", 64'(mem_req), 64'h0);
    step();
    check("t1_mem_req", 64'(mem_req), 64'h1);
    check("t1_busy",    64'(busy),    64'h1);
    e = sb.pop_front();
    check("t1_mem_addr", 64'(mem_addr), 64'(e.addr));
    repeat (3) step();
    mem_avail = 1'b1;
    mem_pixel = 32'hAABB_CCDD;
    step();
    mem_avail = 1'b0;
    check("t1_rsp_avail", 64'(rsp_avail), 64'h1);
    check("t1_rsp_pixel", 64'(rsp_pixel), 64'hAABB_CCDD);
    check("t1_busy_done", 64'(busy),      64'h0);
    step();
    check("t1_rsp_single", 64'(rsp_avail), 64'h0);
    check("t1_rsp_hold",   64'(rsp_pixel), 64'hAABB_CCDD);

    // fairness from a fresh pointer, twice
    res = 1'b1;
    step();
    res = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int unsigned i = 0; i < 4; i++) drive_req(i, 32'(i) * 32'h10, 1'b1);
      step();
      req_pixel = '0;
      for (int k = 0; k < 4; k++) serve(2, 32'hC0DE_0000 + 32'(rep * 16 + k));
    end

    // overflow on a second pulse before grant
    drive_req(2, 32'h0000_0200, 1'b1);
    step();
    req_pixel = '0;
    drive_req(2, 32'h0000_0300, 1'b0);
    step();
    req_pixel = '0;
    check("t3_overflow", 64'(err_overflow), 64'h1);
    serve(2, 32'h2222_0000);
    repeat (2) step();
    check("t3_no_extra_busy", 64'(busy),    64'h0);
    check("t3_no_extra_req",  64'(mem_req), 64'h0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t3_ov_cleared", 64'(err_overflow), 64'h0);

    // watchdog expiry after 8 WAIT cycles, late reply ignored
    check("t4_err_to_pre", 64'(err_timeout), 64'h0);
    drive_req(3, 32'h0000_0330, 1'b1);
    step();
    req_pixel = '0;
    step();
    check("t4_mem_req", 64'(mem_req), 64'h1);
    e = sb.pop_front();
    check("t4_mem_addr", 64'(mem_addr), 64'(e.addr));
    repeat (7) step();
    check("t4_still_busy", 64'(busy),      64'h1);
    check("t4_no_rsp_yet", 64'(rsp_avail), 64'h0);
    step();
    check("t4_rsp_avail", 64'(rsp_avail),   64'h8);
    check("t4_rsp_pixel", 64'(rsp_pixel),   64'hDEAD_BEEF);
    check("t4_err_to",    64'(err_timeout), 64'h1);
    check("t4_idle",      64'(busy),        64'h0);
    mem_avail = 1'b1;
    mem_pixel = 32'h1234_5678;
    step();
    mem_avail = 1'b0;
    check("t4_late_ignored", 64'(rsp_avail), 64'h0);
    check("t4_pixel_held",   64'(rsp_pixel), 64'hDEAD_BEEF);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t4_to_cleared", 64'(err_timeout), 64'h0);

    // reset during WAIT drops the access
    drive_req(0, 32'h0000_0500, 1'b1);
    step();
    req_pixel = '0;
    step();
    check("t5_mem_req", 64'(mem_req), 64'h1);
    e = sb.pop_front();
    check("t5_mem_addr", 64'(mem_addr), 64'(e.addr));
    step();
    res = 1'b1;
    step();
    res = 1'b0;
    check("t5_rst_busy",      64'(busy),      64'h0);
    check("t5_rst_mem_addr",  64'(mem_addr),  64'h0);
    check("t5_rst_rsp_pixel", 64'(rsp_pixel), 64'h0);
    mem_avail = 1'b1;
    mem_pixel = 32'h5555_5555;
    step();
    mem_avail = 1'b0;
    check("t5_stale_ignored", 64'(rsp_avail), 64'h0);
    drive_req(1, 32'h0000_0510, 1'b1);
    step();
    req_pixel = '0;
    serve(2, 32'h5100_0000);

    // re-request while own access is in WAIT
    drive_req(1, 32'h0000_0040, 1'b1);
    step();
    req_pixel = '0;
    step();
    check("t6_mem_req", 64'(mem_req), 64'h1);
    e = sb.pop_front();
    check("t6_mem_addr", 64'(mem_addr), 64'(e.addr));
    drive_req(1, 32'h0000_0044, 1'b1);
    step();
    req_pixel = '0;
    step();
    mem_avail = 1'b1;
    mem_pixel = 32'h4040_4040;
    step();
    mem_avail = 1'b0;
    check("t6_rsp_avail", 64'(rsp_avail),    64'h2);
    check("t6_rsp_pixel", 64'(rsp_pixel),    64'h4040_4040);
    check("t6_no_ov",     64'(err_overflow), 64'h0);
    serve(2, 32'h4444_4444);
    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
